// File: rtl/snn_pkg.sv
// Shared types and default constants for the spike-count decoder slice.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned DEF_N_CH   = 2;
    localparam int unsigned DEF_WINDOW = 64;
    localparam int unsigned DEF_CNT_W  = 8;

endpackage

// File: rtl/spike_counter.sv
// Saturating per-channel spike counter with synchronous clear and enable.
module spike_counter #(
    parameter int unsigned CNT_W = snn_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] next_count
);

    // next_count is exposed so the parent can rank the final sample without waiting a cycle
    always_comb begin
        next_count = count;
        if (inc && (count != '1)) begin
            next_count = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/spike_count_decoder.sv
// Counts spikes per channel over a fixed window and reports the arg-max channel.
module spike_count_decoder
    import snn_pkg::*;
#(
    parameter int unsigned N_CH   = DEF_N_CH,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    localparam int unsigned WIN_W = 16,
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_CH-1:0]       spike_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*CNT_W-1:0] counts,
    output logic [IDX_W-1:0]      winner,
    output logic                  tie
);

    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] nxt [N_CH];
    logic [IDX_W-1:0] max_idx;
    logic             max_tie;

    assign cnt_clear = (state == IDLE) && start;
    assign cnt_en    = (state == COUNT);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (cnt_clear),
            .en         (cnt_en),
            .inc        (spike_in[g]),
            .count      (counts[g*CNT_W +: CNT_W]),
            .next_count (nxt[g])
        );
    end

    // Ranked on the post-update values so the last sampled edge is included
    always_comb begin
        logic [CNT_W-1:0] best;
        best    = nxt[0];
        max_idx = '0;
        max_tie = 1'b0;
        for (int unsigned i = 1; i < N_CH; i++) begin
            if (nxt[i] > best) begin
                best    = nxt[i];
                max_idx = i[IDX_W-1:0];
                max_tie = 1'b0;
            end else if (nxt[i] == best) begin
                max_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_cnt   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            winner    <= '0;
            tie       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COUNT;
                        win_cnt <= WIN_W'(WINDOW - 1);
                        busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    if (win_cnt == '0) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        winner    <= max_idx;
                        tie       <= max_tie;
                    end else begin
                        win_cnt <= win_cnt - WIN_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_count_decoder.sv
// Directed bench: two decoder instances (8-cycle window, and 12-cycle window with 3-bit counts).
module tb_spike_count_decoder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, busy_a, out_valid_a, out_ready_a, winner_a, tie_a;
    logic [1:0]  spike_a;
    logic [15:0] counts_a;

    logic        start_b, busy_b, out_valid_b, out_ready_b, winner_b, tie_b;
    logic [1:0]  spike_b;
    logic [5:0]  counts_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spike_count_decoder #(.N_CH(2), .WINDOW(8), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .spike_in  (spike_a),
        .busy      (busy_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .counts    (counts_a),
        .winner    (winner_a),
        .tie       (tie_a)
    );

    spike_count_decoder #(.N_CH(2), .WINDOW(12), .CNT_W(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .spike_in  (spike_b),
        .busy      (busy_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .counts    (counts_b),
        .winner    (winner_b),
        .tie       (tie_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a window on dut_a, feeds 8 two-bit patterns (cycle 0 in the LSBs) and
    // optionally pulses start during the window; checks the exact latency edge.
    task automatic run_a(input logic [15:0] pats, input int start_at);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            spike_a = pats[i*2 +: 2];
            start_a = (i == start_at);
            tick(1);
            if (i == 6) check("valid_not_early", {31'd0, out_valid_a}, 32'd0);
        end
        start_a = 1'b0;
        spike_a = 2'b00;
        check("valid_on_time", {31'd0, out_valid_a}, 32'd1);
    endtask

    task automatic handshake_a(input logic with_start);
        out_ready_a = 1'b1;
        start_a     = with_start;
        tick(1);
        out_ready_a = 1'b0;
        start_a     = 1'b0;
        check("idle_busy", {31'd0, busy_a}, 32'd0);
        check("idle_valid", {31'd0, out_valid_a}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; spike_a = 2'b00; out_ready_a = 1'b0;
        start_b = 1'b0; spike_b = 2'b00; out_ready_b = 1'b0;
        tick(2);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_counts", {16'd0, counts_a}, 32'd0);
        check("rst_winner", {31'd0, winner_a}, 32'd0);
        check("rst_tie", {31'd0, tie_a}, 32'd0);
        check("rst_counts_b", {26'd0, counts_b}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // ch0 every cycle
        run_a({8{2'b01}}, -1);
        check("c1_counts", {16'd0, counts_a}, 32'h0008);
        check("c1_winner", {31'd0, winner_a}, 32'd0);
        check("c1_tie", {31'd0, tie_a}, 32'd0);
        handshake_a(1'b0);
        spike_a = 2'b11;
        tick(2);
        spike_a = 2'b00;
        check("idle_retain_counts", {16'd0, counts_a}, 32'h0008);
        check("idle_no_start", {31'd0, busy_a}, 32'd0);

        // ch0 x3, ch1 x5, then a long stall with noise on inputs
        run_a({2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11}, -1);
        for (int i = 0; i < 10; i++) begin
            spike_a = 2'b11;
            start_a = i[0];
            tick(1);
            check("hold_counts", {16'd0, counts_a}, 32'h0503);
            check("hold_busy", {31'd0, busy_a}, 32'd1);
            check("hold_valid", {31'd0, out_valid_a}, 32'd1);
        end
        spike_a = 2'b00;
        start_a = 1'b0;
        check("c2_winner", {31'd0, winner_a}, 32'd1);
        check("c2_tie", {31'd0, tie_a}, 32'd0);
        handshake_a(1'b1);
        tick(1);
        check("hs_start_ignored", {31'd0, busy_a}, 32'd0);

        // equal counts, then all-zero
        run_a({{4{2'b00}}, {4{2'b11}}}, -1);
        check("c3_counts", {16'd0, counts_a}, 32'h0404);
        check("c3_winner", {31'd0, winner_a}, 32'd0);
        check("c3_tie", {31'd0, tie_a}, 32'd1);
        handshake_a(1'b0);
        run_a(16'h0000, -1);
        check("c4_counts", {16'd0, counts_a}, 32'h0000);
        check("c4_winner", {31'd0, winner_a}, 32'd0);
        check("c4_tie", {31'd0, tie_a}, 32'd1);
        handshake_a(1'b0);

        // start pulsed mid-window must not restart or stretch it
        run_a({8{2'b01}}, 3);
        check("c5_counts", {16'd0, counts_a}, 32'h0008);
        handshake_a(1'b1);

        // reset at the fourth sampled edge, with start asserted on the same edge
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        spike_a = 2'b11;
        tick(3);
        rst_n   = 1'b0;
        start_a = 1'b1;
        tick(1);
        rst_n   = 1'b1;
        start_a = 1'b0;
        spike_a = 2'b00;
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_valid", {31'd0, out_valid_a}, 32'd0);
        check("abort_counts", {16'd0, counts_a}, 32'd0);
        check("abort_tie", {31'd0, tie_a}, 32'd0);
        tick(8);
        check("abort_no_valid", {31'd0, out_valid_a}, 32'd0);
        run_a({8{2'b10}}, -1);
        check("c6_counts", {16'd0, counts_a}, 32'h0800);
        check("c6_winner", {31'd0, winner_a}, 32'd1);
        check("c6_tie", {31'd0, tie_a}, 32'd0);
        handshake_a(1'b0);

        // saturation: 12 spikes into a 3-bit counter
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        spike_b = 2'b01;
        tick(11);
        check("b_valid_not_early", {31'd0, out_valid_b}, 32'd0);
        tick(1);
        spike_b = 2'b00;
        check("b_valid_on_time", {31'd0, out_valid_b}, 32'd1);
        check("b_counts_sat", {26'd0, counts_b}, 32'h07);
        check("b_winner", {31'd0, winner_b}, 32'd0);
        check("b_tie", {31'd0, tie_b}, 32'd0);
        out_ready_b = 1'b1;
        tick(1);
        out_ready_b = 1'b0;
        check("b_idle", {31'd0, busy_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
